multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the RISC-V datapath.
- Replaces the single-cycle opcode decoder with a Moore FSM that steps fetch/decode/execute/memory/writeback over several cycles.
- Drives one shared instruction/data memory through a req/ready handshake.
- Covers R-type, ld, sd and beq; traps on illegal opcodes and memory timeouts. Also keeps a retired-instruction counter.

---
 rtl/rv_ctrl_pkg.sv | 35 +++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/multicycle_control_fsm.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control sequencer.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_RS2  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    WB_R,
    MEM_ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH,
    TRAP
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; flags when the wait limit is reached.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q;

  // Clear wins over count; saturate at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !timeout) begin
      count_q <= count_q + W'(1);
    end
  end

  assign timeout = (count_q == W'(LIMIT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer: fetch/decode/execute/memory/writeback over several cycles.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       ALUOp,
  output logic             reg_write,
  output logic             MemtoReg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             wait_en, wait_clr, wait_timeout;

  // Any state change restarts the wait count, so each wait state begins at zero.
  assign wait_clr = (state_d != state_q);
  assign wait_en  = (state_q inside {FETCH, MEM_RD, MEM_WR}) && !mem_ready;

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (wait_clr),
    .en     (wait_en),
    .timeout(wait_timeout)
  );

  // State, trap cause and retired counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic; mem_ready beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    retire  = 1'b0;
    unique case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else if (wait_timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        if (opcode == OP_RTYPE) begin
          state_d = EXEC_R;
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d = MEM_ADDR;
        end else if (opcode == OP_BRANCH) begin
          state_d = BRANCH;
        end else begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      EXEC_R:   state_d = WB_R;
      WB_R: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      MEM_ADDR: state_d = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready) begin
          state_d = WB_MEM;
        end else if (wait_timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      WB_MEM: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (wait_timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      BRANCH: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      TRAP:     state_d = TRAP;
      default:  state_d = IDLE;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // Control outputs decoded from state; FETCH completion strobes also look at mem_ready.
  always_comb begin
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    alusrc_a      = 1'b0;
    alusrc_b      = ALUB_RS2;
    ALUOp         = ALUOP_ADD;
    reg_write     = 1'b0;
    MemtoReg      = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        alusrc_b = ALUB_FOUR;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      DECODE:   alusrc_b = ALUB_IMM;
      EXEC_R: begin
        alusrc_a = 1'b1;
        ALUOp    = ALUOP_FUNCT;
      end
      WB_R:     reg_write = 1'b1;
      MEM_ADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = ALUB_IMM;
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      WB_MEM: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      BRANCH: begin
        alusrc_a      = 1'b1;
        ALUOp         = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with hand-computed control vectors.
module tb_multicycle_control_fsm;

  logic        clk, reset, run, mem_ready;
  logic [6:0]  opcode;
  logic        mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic        pc_source, alusrc_a, reg_write, MemtoReg, trap;
  logic [1:0]  alusrc_b, ALUOp, trap_cause;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;

  // Field order: req rd wr iord irw pcw pwc psrc asa asb[2] aluop[2] rw m2r trap cause[2]
  logic [17:0] ctl;
  assign ctl = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                pc_source, alusrc_a, alusrc_b, ALUOp, reg_write, MemtoReg, trap, trap_cause};

  localparam logic [17:0] C_IDLE     = 18'b0_0_0_0_0_0_0_0_0_00_00_0_0_0_00;
  localparam logic [17:0] C_FETCH_W  = 18'b1_1_0_0_0_0_0_0_0_01_00_0_0_0_00;
  localparam logic [17:0] C_FETCH_R  = 18'b1_1_0_0_1_1_0_0_0_01_00_0_0_0_00;
  localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_0_0_0_0_10_00_0_0_0_00;
  localparam logic [17:0] C_EXEC_R   = 18'b0_0_0_0_0_0_0_0_1_00_10_0_0_0_00;
  localparam logic [17:0] C_WB_R     = 18'b0_0_0_0_0_0_0_0_0_00_00_1_0_0_00;
  localparam logic [17:0] C_MEM_ADDR = 18'b0_0_0_0_0_0_0_0_1_10_00_0_0_0_00;
  localparam logic [17:0] C_MEM_RD   = 18'b1_1_0_1_0_0_0_0_0_00_00_0_0_0_00;
  localparam logic [17:0] C_WB_MEM   = 18'b0_0_0_0_0_0_0_0_0_00_00_1_1_0_00;
  localparam logic [17:0] C_MEM_WR   = 18'b1_0_1_1_0_0_0_0_0_00_00_0_0_0_00;
  localparam logic [17:0] C_BRANCH   = 18'b0_0_0_0_0_0_1_1_1_00_01_0_0_0_00;
  localparam logic [17:0] C_TRAP_ILL = 18'b0_0_0_0_0_0_0_0_0_00_00_0_0_1_01;
  localparam logic [17:0] C_TRAP_TO  = 18'b0_0_0_0_0_0_0_0_0_00_00_0_0_1_10;

  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011;
  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPX = 7'b1111111;

  multicycle_control_fsm #(
    .MEM_TIMEOUT(4),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .alusrc_a     (alusrc_a),
    .alusrc_b     (alusrc_b),
    .ALUOp        (ALUOp),
    .reg_write    (reg_write),
    .MemtoReg     (MemtoReg),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      failures++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (retired !== 32'd0) begin
      failures++; $display("FAIL reset_retired: got %0d expected 0", retired);
    end
    // Stay in IDLE without run.
    @(posedge clk); #1;
    checks++;
    if (ctl !== C_IDLE) begin
      failures++; $display("FAIL idle_hold: got %b expected %b", ctl, C_IDLE);
    end
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_FETCH_W) begin
      failures++; $display("FAIL run_to_fetch: got %b expected %b", ctl, C_FETCH_W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [17:0] exp [4];
    exp[0] = C_FETCH_R; exp[1] = C_DECODE; exp[2] = C_EXEC_R; exp[3] = C_WB_R;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; opcode = OPR;
      @(negedge clk);
      checks++;
      if (ctl !== exp[i]) begin
        failures++; $display("FAIL rtype cycle %0d: got %b expected %b", i, ctl, exp[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (retired !== 32'd1) begin
      failures++; $display("FAIL rtype_retired: got %0d expected 1", retired);
    end
  endtask

  task automatic test_load_wait();
    logic [17:0] exp [8];
    logic        rdy [8];
    exp[0] = C_FETCH_R; exp[1] = C_DECODE; exp[2] = C_MEM_ADDR; exp[3] = C_MEM_RD;
    exp[4] = C_MEM_RD;  exp[5] = C_MEM_RD; exp[6] = C_MEM_RD;   exp[7] = C_WB_MEM;
    rdy[0] = 1; rdy[1] = 1; rdy[2] = 1; rdy[3] = 0; rdy[4] = 0; rdy[5] = 0; rdy[6] = 1;
    rdy[7] = 1;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i]; opcode = OPL;
      @(negedge clk);
      checks++;
      if (ctl !== exp[i]) begin
        failures++; $display("FAIL load cycle %0d: got %b expected %b", i, ctl, exp[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (retired !== 32'd2) begin
      failures++; $display("FAIL load_retired: got %0d expected 2", retired);
    end
  endtask

  task automatic test_store_branch();
    logic [17:0] exp [7];
    logic [6:0]  op [7];
    exp[0] = C_FETCH_R; exp[1] = C_DECODE; exp[2] = C_MEM_ADDR; exp[3] = C_MEM_WR;
    exp[4] = C_FETCH_R; exp[5] = C_DECODE; exp[6] = C_BRANCH;
    op[0] = OPS; op[1] = OPS; op[2] = OPS; op[3] = OPS; op[4] = OPB; op[5] = OPB; op[6] = OPB;
    for (int i = 0; i < 7; i++) begin
      mem_ready = 1'b1; opcode = op[i];
      if (i == 4) begin
        checks++;
        if (retired !== 32'd3) begin
          failures++; $display("FAIL store_retired: got %0d expected 3", retired);
        end
      end
      @(negedge clk);
      checks++;
      if (ctl !== exp[i]) begin
        failures++; $display("FAIL sd_beq cycle %0d: got %b expected %b", i, ctl, exp[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (retired !== 32'd4) begin
      failures++; $display("FAIL branch_retired: got %0d expected 4", retired);
    end
  endtask

  task automatic test_illegal_and_async_reset();
    logic [17:0] exp [3];
    exp[0] = C_FETCH_R; exp[1] = C_DECODE; exp[2] = C_TRAP_ILL;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; opcode = OPX;
      @(negedge clk);
      checks++;
      if (ctl !== exp[i]) begin
        failures++; $display("FAIL illegal cycle %0d: got %b expected %b", i, ctl, exp[i]);
      end
      @(posedge clk); #1;
    end
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run = 1'b0;
    checks++;
    if (ctl !== C_TRAP_ILL) begin
      failures++; $display("FAIL trap_sticky: got %b expected %b", ctl, C_TRAP_ILL);
    end
    // Reset asserted between clock edges must take effect at once.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      failures++; $display("FAIL async_reset_ctl: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (retired !== 32'd0) begin
      failures++; $display("FAIL async_reset_retired: got %0d expected 0", retired);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    run = 1'b1; mem_ready = 1'b0; opcode = OPR;
    @(posedge clk); #1;
    run = 1'b0;
    // Four wait cycles allowed; the fifth still-not-ready cycle traps.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== C_FETCH_W) begin
        failures++; $display("FAIL timeout wait %0d: got %b expected %b", i, ctl, C_FETCH_W);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ctl !== C_TRAP_TO) begin
      failures++; $display("FAIL timeout_trap: got %b expected %b", ctl, C_TRAP_TO);
    end
    reset = 1'b1;
    #2;
    reset = 1'b0;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    // Ready on the cycle the counter hits the limit: no trap.
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      @(negedge clk);
      checks++;
      if (ctl !== ((i == 4) ? C_FETCH_R : C_FETCH_W)) begin
        failures++; $display("FAIL late_ready cycle %0d: got %b", i, ctl);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (ctl !== C_DECODE) begin
      failures++; $display("FAIL late_ready_decode: got %b expected %b", ctl, C_DECODE);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_branch();
    test_illegal_and_async_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
